// File: rtl/inst_sram_responder_pkg.sv
// Shared types and constants for the instruction-side SRAM-like responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_sram_responder_pkg;

    // Word index carried in a response tag: the full byte address minus the
    // two byte-offset bits. Each instance keeps only its low IDX_W bits.
    localparam int TAG_IDX_W = 30;

    // Returned for write requests.
    localparam logic [31:0] INST_SRAM_ZERO = 32'h0;

    // Per-request tag travelling down the in-order response delay line.
    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [TAG_IDX_W-1:0] idx;
    } rsp_tag_t;

    // Word index of a byte address.
    function automatic logic [TAG_IDX_W-1:0] word_idx(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/inst_sram_responder_if.sv
// SRAM-like fetch bus between the pre-IF/IF stages and the instruction memory.
// Latency: n/a (wiring only).
// Backpressure: addr_ok throttles requests; data_ok has no back-pressure.
interface inst_sram_responder_if;
    import inst_sram_responder_pkg::*;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    // Core side: issues requests, consumes responses.
    modport master (
        output req, wr, size, addr,
        input  addr_ok, data_ok, rdata
    );

    // Memory side: accepts requests, produces responses.
    modport slave (
        input  req, wr, size, addr,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/inst_ram_1r1w.sv
// Word RAM, one synchronous read port and one write port, read-before-write.
// Latency: read data valid the cycle after the read enable edge.
// Backpressure: none; both ports accept every cycle.
module inst_ram_1r1w #(
    parameter int IDX_W = 14
) (
    input  logic             clk,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [31:0]      o_rd_data,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [31:0]      i_wr_data
);

    localparam int DEPTH = 1 << IDX_W;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data;

    // Write and registered read in one block so a same-index collision
    // returns the old word (read-first BRAM mode).
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/inst_sram_responder.sv
// In-order instruction fetch responder: bounded outstanding requests over an internal RAM.
// Latency: LATENCY cycles from accept to the single-cycle data_ok.
// Backpressure: addr_ok drops at MAX_OUTST outstanding or on addr_stall; responses are never stalled.
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int IDX_W     = 14,
    parameter int LATENCY   = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    inst_sram_responder_if.slave bus,
    input  logic                 addr_stall,
    input  logic                 ld_en,
    input  logic [IDX_W-1:0]     ld_idx,
    input  logic [31:0]          ld_data
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic             r_reset_q;
    logic [CNT_W-1:0] r_outst;
    rsp_tag_t         r_tag [LATENCY];

    logic             w_addr_ok;
    logic             w_accept;
    logic             w_data_ok;
    rsp_tag_t         w_new_tag;
    logic             w_rd_en;
    logic [IDX_W-1:0] w_rd_idx;
    logic [31:0]      w_ram_q;
    logic             w_unused;

    // The last delay-line stage is the response slot.
    assign w_data_ok = r_tag[LATENCY-1].valid;

    // A retire in the same cycle frees a slot, so a full responder can still accept.
    assign w_addr_ok = !reset && !r_reset_q && !addr_stall &&
                       ((r_outst < CNT_W'(MAX_OUTST)) || w_data_ok);
    assign w_accept  = bus.req && w_addr_ok;

    // Tag for the request accepted this cycle (valid only on accept).
    always_comb begin
        w_new_tag       = '0;
        w_new_tag.valid = w_accept;
        w_new_tag.wr    = bus.wr;
        w_new_tag.idx   = word_idx(bus.addr);
    end

    // Hold addr_ok low for one cycle after reset releases.
    always_ff @(posedge clk) begin
        r_reset_q <= reset;
    end

    // Outstanding-request count: +1 on accept, -1 on retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outst <= '0;
        end else if (w_accept && !w_data_ok) begin
            r_outst <= r_outst + CNT_W'(1);
        end else if (!w_accept && w_data_ok) begin
            r_outst <= r_outst - CNT_W'(1);
        end
    end

    // In-order delay line; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_new_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // The RAM read is issued one stage before the response slot so its
    // registered output lines up with data_ok. Writes skip the read.
    if (LATENCY == 1) begin : g_rd_at_accept
        assign w_rd_en  = w_accept && !bus.wr;
        assign w_rd_idx = w_new_tag.idx[IDX_W-1:0];
    end else begin : g_rd_in_line
        assign w_rd_en  = r_tag[LATENCY-2].valid && !r_tag[LATENCY-2].wr;
        assign w_rd_idx = r_tag[LATENCY-2].idx[IDX_W-1:0];
    end

    inst_ram_1r1w #(
        .IDX_W (IDX_W)
    ) u_ram (
        .clk       (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_ram_q),
        .i_wr_en   (ld_en),
        .i_wr_idx  (ld_idx),
        .i_wr_data (ld_data)
    );

    assign bus.addr_ok = w_addr_ok;
    assign bus.data_ok = w_data_ok;
    // rdata is forced to zero outside a read response so stale RAM output never leaks.
    assign bus.rdata   = (w_data_ok && !r_tag[LATENCY-1].wr) ? w_ram_q : INST_SRAM_ZERO;

    // Size, byte offset and the aliased upper index bits are intentionally ignored.
    assign w_unused = ^{bus.size, bus.addr[1:0], r_tag[LATENCY-1].idx};

endmodule
